// File: rtl/timer_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper
// for the countdown timer sequencing controller.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_TICK_DIV        = 100000;
  localparam int DEF_ALARM_CYCLES    = 500000000;
  localparam int DEF_BLINK_DIV       = 25000000;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchroniser, debounce and a registered
// single-cycle pulse on each rising edge of the accepted level.
module btn_cond import timer_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The accepted level flips only on the last of a run of differing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing controller: button conditioning and arbitration, decrement
// tick prescaler, EDIT/RUN/PAUSE/ALARM state machine and alarm blink timer.
module timer_ctrl import timer_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int ALARM_CYCLES    = DEF_ALARM_CYCLES,
  parameter int BLINK_DIV       = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_d,
  input  logic       btn_r,
  input  logic       tmr_edit,
  input  logic       tmr_done,
  output logic       tmr_bc,
  output logic       tmr_bl,
  output logic       tmr_bd,
  output logic       tmr_br,
  output logic       tmr_tick,
  output logic       alarm_o,
  output logic [1:0] state_o
);

  localparam int            TW         = cnt_width(TICK_DIV);
  localparam int            AW         = cnt_width(ALARM_CYCLES);
  localparam int            BW         = cnt_width(BLINK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic press_c, press_l, press_d, press_r;
  logic sel_c, sel_l, sel_d, sel_r, any_press;
  logic edit_prev_q, edit_fall, alarm_exit;
  state_t state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic bc_q, bl_q, bd_q, br_q, tick_q, alarm_q;
  logic bc_d, bl_d, bd_d, br_d, tick_d, alarm_d;

  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_c (.clk(clk), .rst_n(rst_n), .btn_i(btn_c), .press_o(press_c));
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (.clk(clk), .rst_n(rst_n), .btn_i(btn_l), .press_o(press_l));
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_d (.clk(clk), .rst_n(rst_n), .btn_i(btn_d), .press_o(press_d));
  btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (.clk(clk), .rst_n(rst_n), .btn_i(btn_r), .press_o(press_r));

  // One press per cycle, L > D > C > R; losers are simply dropped.
  always_comb begin
    sel_l      = press_l;
    sel_d      = press_d & ~press_l;
    sel_c      = press_c & ~press_l & ~press_d;
    sel_r      = press_r & ~press_l & ~press_d & ~press_c;
    any_press  = press_l | press_d | press_c | press_r;
    edit_fall  = edit_prev_q & ~tmr_edit;
    alarm_exit = (state_q == ST_ALARM) && (any_press || (alarm_cnt_q == ALARM_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EDIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EDIT:  if (edit_fall) state_d = ST_RUN;
      ST_RUN: begin
        if (tmr_done)           state_d = ST_ALARM;
        else if (sel_l | sel_d) state_d = ST_EDIT;
        else if (sel_c)         state_d = ST_PAUSE;
        else                    state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (sel_l | sel_d)      state_d = ST_EDIT;
        else if (sel_c)         state_d = ST_RUN;
        else                    state_d = ST_PAUSE;
      end
      ST_ALARM: if (alarm_exit) state_d = ST_EDIT;
      default:  state_d = ST_EDIT;
    endcase
  end

  // A press that leaves RUN/PAUSE suppresses the tick; the counter then keeps its phase.
  always_comb begin
    bc_d = 1'b0; bl_d = 1'b0; bd_d = 1'b0; br_d = 1'b0;
    tick_d = 1'b0; alarm_d = 1'b0;
    case (state_q)
      ST_EDIT: begin
        bc_d = sel_c; bl_d = sel_l; bd_d = sel_d; br_d = sel_r;
      end
      ST_RUN: begin
        if (tmr_done) begin
          alarm_d = 1'b1;
        end else begin
          bl_d   = sel_l;
          bd_d   = sel_d;
          tick_d = (tick_cnt_q == TICK_LAST) && (state_d == ST_RUN);
        end
      end
      ST_PAUSE: begin
        bl_d = sel_l; bd_d = sel_d;
      end
      ST_ALARM: begin
        if (alarm_exit) begin
          bd_d = 1'b1;
        end else begin
          alarm_d = (blink_cnt_q == BLINK_LAST) ? ~alarm_q : alarm_q;
        end
      end
      default: begin
        bc_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    alarm_cnt_d = '0;
    blink_cnt_d = '0;
    if (state_q == ST_EDIT && state_d == ST_RUN) begin
      tick_cnt_d = '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
    if (state_q == ST_ALARM && state_d == ST_ALARM) begin
      alarm_cnt_d = alarm_cnt_q + 1'b1;
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    end else begin
      alarm_cnt_d = '0;
      blink_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_prev_q <= 1'b0;
      tick_cnt_q  <= '0;
      alarm_cnt_q <= '0;
      blink_cnt_q <= '0;
      bc_q <= 1'b0; bl_q <= 1'b0; bd_q <= 1'b0; br_q <= 1'b0;
      tick_q <= 1'b0; alarm_q <= 1'b0;
    end else begin
      edit_prev_q <= tmr_edit;
      tick_cnt_q  <= tick_cnt_d;
      alarm_cnt_q <= alarm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      bc_q <= bc_d; bl_q <= bl_d; bd_q <= bd_d; br_q <= br_d;
      tick_q <= tick_d; alarm_q <= alarm_d;
    end
  end

  assign tmr_bc   = bc_q;
  assign tmr_bl   = bl_q;
  assign tmr_bd   = bd_q;
  assign tmr_br   = br_q;
  assign tmr_tick = tick_q;
  assign alarm_o  = alarm_q;
  assign state_o  = state_q;

endmodule
